// File: rtl/wishbone_master_pkg.sv
// Shared types and constants for the Wishbone classic bus initiator.
package wishbone_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } wbm_state_t;

  // Read data returned to the requester when a cycle ends on error or timeout.
  localparam int unsigned WBM_MAX_DATA_WIDTH = 1024;
  localparam logic [WBM_MAX_DATA_WIDTH-1:0] WBM_ERR_RDATA = '0;

  // Word-to-byte address shift for a bus BUS_WIDTH bytes wide.
  function automatic int unsigned wbm_addr_shift(input int unsigned bus_width);
    return $clog2(bus_width);
  endfunction

endpackage

// File: rtl/wb_master_timeout.sv
// Open-cycle watchdog: counts cycles while the bus cycle is open and flags
// expiry on the edge that would complete TIMEOUT_CYCLES open cycles.
module wb_master_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign o_expired = i_run && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/wishbone_classic_master.sv
// Wishbone B3 classic (non-pipelined) initiator driven by up_* register requests.
// Optional open-cycle timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_classic_master
  import wishbone_master_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned BUS_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         up_rreq,
  input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0]   up_raddr,
  output logic                                         up_rack,
  output logic [BUS_WIDTH*8-1:0]                       up_rdata,
  input  logic                                         up_wreq,
  input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0]   up_waddr,
  input  logic [BUS_WIDTH*8-1:0]                       up_wdata,
  output logic                                         up_wack,
  output logic                                         up_err,
  output logic                                         m_wb_cyc,
  output logic                                         m_wb_stb,
  output logic                                         m_wb_we,
  output logic [ADDRESS_WIDTH-1:0]                     m_wb_addr,
  output logic [BUS_WIDTH*8-1:0]                       m_wb_data_o,
  output logic [BUS_WIDTH-1:0]                         m_wb_sel,
  input  logic                                         m_wb_ack,
  input  logic [BUS_WIDTH*8-1:0]                       m_wb_data_i,
  input  logic                                         m_wb_err
);

  localparam int unsigned ADDR_SHIFT = wbm_addr_shift(BUS_WIDTH);
  localparam int unsigned WORD_AW    = ADDRESS_WIDTH - ADDR_SHIFT;
  localparam int unsigned DATA_W     = BUS_WIDTH * 8;

  wbm_state_t          r_state;
  wbm_state_t          w_state_nxt;
  logic                r_cyc;
  logic                w_cyc_nxt;
  logic                r_we;
  logic                w_we_nxt;
  logic [WORD_AW-1:0]  r_addr;
  logic [WORD_AW-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                r_rack;
  logic                w_rack_nxt;
  logic                r_wack;
  logic                w_wack_nxt;
  logic                r_err;
  logic                w_err_nxt;

  logic                w_start;
  logic                w_expired;
  logic                w_resp;
  logic                w_fail;

  assign w_start = (r_state == IDLE) && (up_wreq || up_rreq);

`ifdef WB_MASTER_TIMEOUT_EN
  wb_master_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (w_start),
    .i_run     (r_cyc),
    .o_expired (w_expired)
  );
`else
  // No watchdog in this build; TIMEOUT_CYCLES is kept so overrides stay legal.
  assign w_expired = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // A timeout coinciding with a real ack completes normally; err beats ack.
  assign w_resp = m_wb_ack || m_wb_err || w_expired;
  assign w_fail = m_wb_err || (w_expired && !m_wb_ack);

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_rack_nxt  = 1'b0;
    w_wack_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (up_wreq) begin
          w_state_nxt = WRITE;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = up_waddr;
          w_wdata_nxt = up_wdata;
        end else if (up_rreq) begin
          w_state_nxt = READ;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = up_raddr;
        end
      end

      WRITE, READ: begin
        if (w_resp) begin
          w_state_nxt = DONE;
          w_cyc_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_err_nxt   = w_fail;
          if (r_state == READ) begin
            w_rack_nxt  = 1'b1;
            w_rdata_nxt = w_fail ? WBM_ERR_RDATA[DATA_W-1:0] : m_wb_data_i;
          end else begin
            w_wack_nxt  = 1'b1;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_cyc_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rack  <= 1'b0;
      r_wack  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_rack  <= w_rack_nxt;
      r_wack  <= w_wack_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign m_wb_cyc    = r_cyc;
  assign m_wb_stb    = r_cyc;
  assign m_wb_we     = r_we;
  assign m_wb_addr   = ADDRESS_WIDTH'(r_addr) << ADDR_SHIFT;
  assign m_wb_data_o = r_wdata;
  assign m_wb_sel    = '1;
  assign up_rack     = r_rack;
  assign up_wack     = r_wack;
  assign up_err      = r_err;
  assign up_rdata    = r_rdata;

endmodule

// File: tb/tb_wishbone_classic_master.sv
// Scoreboard bench for wishbone_classic_master: planned slave responses,
// expected requester results from a word-memory reference model.
module tb_wishbone_classic_master;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned DW = BW * 8;
  localparam int unsigned WA = AW - 2;
  localparam int unsigned TO = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          up_rreq = 1'b0;
  logic [WA-1:0] up_raddr = '0;
  logic          up_rack;
  logic [DW-1:0] up_rdata;
  logic          up_wreq = 1'b0;
  logic [WA-1:0] up_waddr = '0;
  logic [DW-1:0] up_wdata = '0;
  logic          up_wack;
  logic          up_err;
  logic          m_wb_cyc;
  logic          m_wb_stb;
  logic          m_wb_we;
  logic [AW-1:0] m_wb_addr;
  logic [DW-1:0] m_wb_data_o;
  logic [BW-1:0] m_wb_sel;
  logic          m_wb_ack = 1'b0;
  logic [DW-1:0] m_wb_data_i = '0;
  logic          m_wb_err = 1'b0;

  wishbone_classic_master #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .up_rreq     (up_rreq),
    .up_raddr    (up_raddr),
    .up_rack     (up_rack),
    .up_rdata    (up_rdata),
    .up_wreq     (up_wreq),
    .up_waddr    (up_waddr),
    .up_wdata    (up_wdata),
    .up_wack     (up_wack),
    .up_err      (up_err),
    .m_wb_cyc    (m_wb_cyc),
    .m_wb_stb    (m_wb_stb),
    .m_wb_we     (m_wb_we),
    .m_wb_addr   (m_wb_addr),
    .m_wb_data_o (m_wb_data_o),
    .m_wb_sel    (m_wb_sel),
    .m_wb_ack    (m_wb_ack),
    .m_wb_data_i (m_wb_data_i),
    .m_wb_err    (m_wb_err)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            wr;
    logic [WA-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   waits;
    bit            err;
    bit            noresp;
  } plan_t;

  typedef struct {
    bit            wr;
    bit            err;
    logic [DW-1:0] rdata;
    bit            chk_lat;
  } exp_t;

  plan_t         plan_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [8];
  logic [DW-1:0] slave_mem [8];
  int unsigned   resp_cycle = 0;
  int unsigned   last_rise  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Queue the slave behaviour and the result the requester must see.
  task automatic plan_op(input bit wr, input logic [WA-1:0] a, input logic [DW-1:0] d,
                         input int unsigned waits, input bit err);
    plan_t p;
    exp_t  e;
    p.wr = wr; p.addr = a; p.data = d; p.waits = waits; p.err = err; p.noresp = 1'b0;
    plan_q.push_back(p);
    e.wr = wr; e.err = err; e.chk_lat = 1'b1; e.rdata = '0;
    if (wr) begin
      if (!err) model_mem[a[2:0]] = d;
    end else begin
      e.rdata = err ? '0 : model_mem[a[2:0]];
    end
    exp_q.push_back(e);
  endtask

  task automatic plan_hang(input logic [WA-1:0] a, input logic [DW-1:0] d, input bit expect_timeout);
    plan_t p;
    exp_t  e;
    p.wr = 1'b1; p.addr = a; p.data = d; p.waits = 0; p.err = 1'b0; p.noresp = 1'b1;
    plan_q.push_back(p);
    if (expect_timeout) begin
      e.wr = 1'b1; e.err = 1'b1; e.rdata = '0; e.chk_lat = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_req(input bit dw, input bit dr, input logic [WA-1:0] wa,
                         input logic [WA-1:0] ra, input logic [DW-1:0] wd);
    int unsigned n  = 0;
    bit          wp = dw;
    bit          rp = dr;
    int unsigned wc = 0;
    @(negedge clk);
    up_wreq = dw; up_waddr = wa; up_wdata = wd;
    up_rreq = dr; up_raddr = ra;
    @(negedge clk);
    chk("req_latency", 64'({m_wb_cyc, m_wb_stb, m_wb_we}), 64'({1'b1, 1'b1, dw}));
    while ((wp || rp) && n < 2000) begin
      if (wp && up_wack) begin
        up_wreq = 1'b0; wp = 1'b0; wc = cycle;
      end else if (rp && up_rack) begin
        up_rreq = 1'b0; rp = 1'b0;
      end
      if (wp || rp) begin
        @(negedge clk);
        n++;
      end
    end
    if (wp || rp) begin
      chk("ack_timeout", 64'({wp, rp}), 64'(0));
      up_wreq = 1'b0;
      up_rreq = 1'b0;
    end
    if (dw && dr) chk("b2b_spacing", 64'(last_rise), 64'(wc + 2));
  endtask

  task automatic hang_then_reset(input logic [WA-1:0] a, input logic [DW-1:0] d, input int unsigned hold);
    bit ok = 1'b1;
    plan_hang(a, d, 1'b0);
    @(negedge clk);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    @(negedge clk);
    repeat (hold) begin
      if (!m_wb_cyc) ok = 1'b0;
      @(negedge clk);
    end
    chk("cyc_held_open", 64'(ok), 64'(1));
    rstn = 1'b0;
    @(negedge clk);
    chk("reset_drop", 64'({m_wb_cyc, m_wb_stb, m_wb_we, up_wack}), 64'(0));
    up_wreq = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Bus-level slave: follows the plan queue, checks what the master drives.
  initial begin : slave
    plan_t       cur;
    bit          active = 1'b0;
    bit          done   = 1'b0;
    int unsigned cnt    = 0;
    cur.wr = 1'b0; cur.addr = '0; cur.data = '0; cur.waits = 0; cur.err = 1'b0; cur.noresp = 1'b1;
    forever begin
      @(negedge clk);
      if (done) begin
        m_wb_ack = 1'($urandom_range(0, 1));
        m_wb_err = 1'b0;
        chk("cyc_drop", 64'(m_wb_cyc), 64'(0));
        done   = 1'b0;
        active = 1'b0;
      end else if (m_wb_cyc && m_wb_stb) begin
        if (!active) begin
          active    = 1'b1;
          last_rise = cycle;
          if (plan_q.size() == 0) begin
            chk("unplanned_cycle", 64'(1), 64'(0));
            cur.noresp = 1'b1;
          end else begin
            cur = plan_q.pop_front();
          end
          cnt = cur.waits;
        end
        chk("bus_addr", 64'(m_wb_addr), 64'({cur.addr, 2'b00}));
        chk("bus_we", 64'(m_wb_we), 64'(cur.wr));
        chk("bus_sel", 64'(m_wb_sel), 64'(4'hF));
        if (cur.wr) chk("bus_wdata", 64'(m_wb_data_o), 64'(cur.data));
        if (!cur.noresp) begin
          if (cnt == 0) begin
            if (cur.err) begin
              m_wb_err = 1'b1;
              m_wb_ack = 1'($urandom_range(0, 1));
            end else begin
              m_wb_ack = 1'b1;
            end
            if (cur.wr) begin
              if (!cur.err) slave_mem[cur.addr[2:0]] = m_wb_data_o;
            end else begin
              m_wb_data_i = cur.err ? DW'($urandom) : slave_mem[cur.addr[2:0]];
            end
            resp_cycle = cycle;
            done       = 1'b1;
          end else begin
            cnt--;
            m_wb_data_i = DW'($urandom);
          end
        end
      end else begin
        active   = 1'b0;
        m_wb_ack = 1'b0;
        m_wb_err = 1'b0;
      end
    end
  end

  // Monitor: every ack pulse must match the oldest expected result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (up_wack || up_rack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'({up_wack, up_rack}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ack_kind", 64'({up_wack, up_rack}), e.wr ? 64'(2) : 64'(1));
          chk("ack_err", 64'(up_err), 64'(e.err));
          if (!e.wr) chk("rdata", 64'(up_rdata), 64'(e.rdata));
          chk("cyc_low_at_ack", 64'(m_wb_cyc), 64'(0));
          if (e.chk_lat) chk("ack_latency", 64'(cycle), 64'(resp_cycle + 1));
          else           chk("timeout_open_cycles", 64'(cycle - last_rise), 64'(TO));
        end
      end else if (up_err) begin
        chk("err_without_ack", 64'(up_err), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [WA-1:0] a;
    logic [WA-1:0] b;
    logic [DW-1:0] d;
    int unsigned   kind;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 32'h1000_0000 + DW'(i);
      slave_mem[i] = 32'h1000_0000 + DW'(i);
    end

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({m_wb_cyc, m_wb_stb, m_wb_we, up_rack, up_wack, up_err}), 64'(0));
    chk("rst_addr", 64'(m_wb_addr), 64'(0));
    chk("rst_data_o", 64'(m_wb_data_o), 64'(0));
    chk("rst_rdata", 64'(up_rdata), 64'(0));
    chk("rst_sel", 64'(m_wb_sel), 64'(4'hF));
    rstn = 1'b1;

    plan_op(1'b1, 30'd1, 32'hAAAA_0000, 0, 1'b0);
    run_req(1'b1, 1'b0, 30'd1, 30'd0, 32'hAAAA_0000);

    plan_op(1'b1, 30'd3, 32'h1234_5678, 0, 1'b0);
    run_req(1'b1, 1'b0, 30'd3, 30'd0, 32'h1234_5678);
    plan_op(1'b0, 30'd3, '0, 3, 1'b0);
    run_req(1'b0, 1'b1, 30'd0, 30'd3, '0);

    plan_op(1'b1, 30'd2, 32'hC0DE_F00D, 0, 1'b0);
    plan_op(1'b0, 30'd2, '0, 0, 1'b0);
    run_req(1'b1, 1'b1, 30'd2, 30'd2, 32'hC0DE_F00D);

    plan_op(1'b0, 30'd5, '0, 1, 1'b1);
    run_req(1'b0, 1'b1, 30'd0, 30'd5, '0);

`ifdef WB_MASTER_TIMEOUT_EN
    plan_hang(30'd6, 32'h6666_6666, 1'b1);
    run_req(1'b1, 1'b0, 30'd6, 30'd0, 32'h6666_6666);
`else
    hang_then_reset(30'd6, 32'h6666_6666, 1000);
`endif
    hang_then_reset(30'd7, 32'h7777_7777, 4);

    plan_op(1'b0, 30'd1, '0, 0, 1'b0);
    run_req(1'b0, 1'b1, 30'd0, 30'd1, '0);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      a    = WA'($urandom_range(0, 7));
      b    = WA'($urandom_range(0, 7));
      d    = DW'($urandom);
      if (kind != 1) plan_op(1'b1, a, d, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      if (kind != 0) plan_op(1'b0, b, '0, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      run_req(kind != 1, kind != 0, a, b, d);
    end

    repeat (3) @(negedge clk);
    chk("exp_drained", 64'(exp_q.size()), 64'(0));
    chk("plan_drained", 64'(plan_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
